// File: rtl/lsu_bus_bridge.sv
// Load/store bridge between the core data-memory port and the shared data bus.
// Takes one request at a time, checks size/alignment, runs a valid/ready request
// plus single-cycle response handshake, and returns an extended load result with a
// one-cycle done pulse.
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   core_valid        request strobe (sampled only when idle)
//   core_we           1 = store, 0 = load
//   core_funct3       size code (B/H/W/D, BU/HU/WU, 111 illegal)
//   core_addr         byte address
//   core_wdata        right-aligned store data
//   core_rdata        extended load result, valid with core_done
//   core_done         one-cycle completion pulse
//   core_err          error flag, valid with core_done
//   busy              high from the cycle after accept through the done cycle
//   bus_req_valid     request valid toward memory
//   bus_req_ready     request accepted when valid & ready
//   bus_we            write enable
//   bus_addr          doubleword-aligned address
//   bus_wdata         store data moved to its byte lanes
//   bus_wstrb         byte-lane enables (all ones on reads)
//   bus_rsp_valid     single-cycle response strobe
//   bus_rdata         full aligned doubleword read data
//   bus_rsp_err       response error flag
module lsu_bus_bridge #(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            core_valid,
  input  logic            core_we,
  input  logic [2:0]      core_funct3,
  input  logic [XLEN-1:0] core_addr,
  input  logic [XLEN-1:0] core_wdata,
  output logic [XLEN-1:0] core_rdata,
  output logic            core_done,
  output logic            core_err,
  output logic            busy,
  output logic            bus_req_valid,
  input  logic            bus_req_ready,
  output logic            bus_we,
  output logic [XLEN-1:0] bus_addr,
  output logic [XLEN-1:0] bus_wdata,
  output logic [7:0]      bus_wstrb,
  input  logic            bus_rsp_valid,
  input  logic [XLEN-1:0] bus_rdata,
  input  logic            bus_rsp_err
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  // Counter value seen in the last waiting cycle before the timeout fires.
  localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StReq, StWaitRsp, StDone} state_e;

  state_e              state_q, state_d;
  logic                we_q, we_d;
  logic [2:0]          funct3_q, funct3_d;
  logic [XLEN-1:0]     addr_q, addr_d;
  logic [XLEN-1:0]     wdata_q, wdata_d;
  logic [XLEN-1:0]     rdata_q, rdata_d;
  logic                err_q, err_d;
  logic [CntW-1:0]     cnt_q, cnt_d;

  logic                misaligned;
  logic                illegal;
  logic [5:0]          lane_shift;
  logic [XLEN-1:0]     rsp_shifted;
  logic [XLEN-1:0]     load_ext;
  logic                sext;
  logic [7:0]          size_mask;
  logic                in_req;
  logic                in_done;

  // Alignment check on the live request, only meaningful in StIdle.
  always_comb begin
    unique case (core_funct3[1:0])
      2'b00: misaligned = 1'b0;
      2'b01: misaligned = core_addr[0];
      2'b10: misaligned = |core_addr[1:0];
      2'b11: misaligned = |core_addr[2:0];
    endcase
  end

  assign illegal = (core_funct3 == 3'b111);

  assign lane_shift  = {addr_q[2:0], 3'b000};
  assign rsp_shifted = bus_rdata >> lane_shift;
  assign sext        = ~funct3_q[2];

  always_comb begin
    unique case (funct3_q[1:0])
      2'b00: load_ext = {{(XLEN-8){sext & rsp_shifted[7]}}, rsp_shifted[7:0]};
      2'b01: load_ext = {{(XLEN-16){sext & rsp_shifted[15]}}, rsp_shifted[15:0]};
      2'b10: load_ext = {{(XLEN-32){sext & rsp_shifted[31]}}, rsp_shifted[31:0]};
      2'b11: load_ext = rsp_shifted;
    endcase
  end

  always_comb begin
    unique case (funct3_q[1:0])
      2'b00: size_mask = 8'h01;
      2'b01: size_mask = 8'h03;
      2'b10: size_mask = 8'h0F;
      2'b11: size_mask = 8'hFF;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    cnt_d    = cnt_q;

    unique case (state_q)
      StIdle: begin
        if (core_valid) begin
          we_d     = core_we;
          funct3_d = core_funct3;
          addr_d   = core_addr;
          wdata_d  = core_wdata;
          rdata_d  = '0;
          if (misaligned || illegal) begin
            err_d   = 1'b1;
            state_d = StDone;
          end else begin
            err_d   = 1'b0;
            state_d = StReq;
          end
        end
      end
      StReq: begin
        if (bus_req_ready) begin
          cnt_d   = '0;
          state_d = StWaitRsp;
        end
      end
      StWaitRsp: begin
        cnt_d = cnt_q + CntW'(1);
        // A response in the timeout cycle takes priority over the timeout.
        if (bus_rsp_valid) begin
          err_d   = bus_rsp_err;
          rdata_d = (we_q || bus_rsp_err) ? '0 : load_ext;
          state_d = StDone;
        end else if ((TIMEOUT != 0) && (cnt_q == TimeoutLast)) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  // Outputs are gated by state so everything reads zero in reset and idle.
  assign in_req  = (state_q == StReq);
  assign in_done = (state_q == StDone);

  assign busy          = (state_q != StIdle);
  assign bus_req_valid = in_req;
  assign bus_we        = in_req & we_q;
  assign bus_addr      = in_req ? {addr_q[XLEN-1:3], 3'b000} : '0;
  assign bus_wdata     = in_req ? (wdata_q << lane_shift) : '0;
  assign bus_wstrb     = !in_req ? 8'h00 : (we_q ? (size_mask << addr_q[2:0]) : 8'hFF);
  assign core_done     = in_done;
  assign core_err      = in_done & err_q;
  assign core_rdata    = in_done ? rdata_q : '0;

endmodule

// File: tb/tb_lsu_bus_bridge.sv
// Self-checking bench for lsu_bus_bridge: directed vector table, reset-abort
// sequence and randomized transactions scored against a transaction-level model.
module tb_lsu_bus_bridge;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_valid;
  logic        core_we;
  logic [2:0]  core_funct3;
  logic [63:0] core_addr;
  logic [63:0] core_wdata;
  logic [63:0] core_rdata;
  logic        core_done;
  logic        core_err;
  logic        busy;
  logic        bus_req_valid;
  logic        bus_req_ready;
  logic        bus_we;
  logic [63:0] bus_addr;
  logic [63:0] bus_wdata;
  logic [7:0]  bus_wstrb;
  logic        bus_rsp_valid;
  logic [63:0] bus_rdata;
  logic        bus_rsp_err;

  lsu_bus_bridge #(.XLEN(64), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .core_valid(core_valid), .core_we(core_we), .core_funct3(core_funct3),
    .core_addr(core_addr), .core_wdata(core_wdata), .core_rdata(core_rdata),
    .core_done(core_done), .core_err(core_err), .busy(busy),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
    .bus_rsp_valid(bus_rsp_valid), .bus_rdata(bus_rdata), .bus_rsp_err(bus_rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [63:0] addr;
    logic [63:0] wdata;
    int          rdly;   // request cycles with ready low before ready is given
    int          rsp_k;  // waiting cycle (1-based) carrying the response
    logic        rsp_err;
    logic [63:0] rdata;
  } stim_t;

  typedef struct {
    bit          req;
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        err;
    logic [63:0] rdata;
    int          done_cyc;  // cycle of the done pulse, accept cycle counted as 1
  } exp_t;

  typedef struct {
    bit          req;
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    bit          unstable;
    int          done_cnt;
    int          done_cyc;
    logic        err;
    logic [63:0] rdata;
    bit          busy_bad;
    logic        busy_after;
  } obs_t;

  typedef struct {
    stim_t s;
    exp_t  e;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Transaction-level reference: outcome derived from size, offset and bus timing.
  function automatic exp_t model(input stim_t s);
    exp_t        e;
    int          sz;
    int          off;
    int          hs;
    logic [63:0] v;
    logic [63:0] mask;
    e   = '{default: '0};
    sz  = 1 << s.f3[1:0];
    off = int'(s.addr[2:0]);
    if (s.f3 == 3'b111 || (off % sz) != 0) begin
      e.err      = 1'b1;
      e.done_cyc = 2;
      return e;
    end
    e.req   = 1'b1;
    e.we    = s.we;
    e.addr  = s.addr & ~64'h7;
    e.wdata = s.wdata << (8 * off);
    e.wstrb = s.we ? 8'(((1 << sz) - 1) << off) : 8'hFF;
    hs      = 2 + s.rdly;
    if (s.rsp_k <= TO) begin
      e.done_cyc = hs + s.rsp_k + 1;
      e.err      = s.rsp_err;
      if (!s.we && !s.rsp_err) begin
        v = s.rdata >> (8 * off);
        if (sz < 8) begin
          mask = (64'd1 << (8 * sz)) - 64'd1;
          v    = v & mask;
          if (!s.f3[2] && v[8*sz-1]) v = v | ~mask;
        end
        e.rdata = v;
      end
    end else begin
      e.done_cyc = hs + TO + 1;
      e.err      = 1'b1;
    end
    return e;
  endfunction

  // Drives one transaction and records what the DUT did. Junk is driven on the
  // core port and on the response channel whenever they must be ignored.
  task automatic run_txn(input stim_t s, output obs_t o);
    int c;
    int req_n;
    int hs;
    bit done_seen;
    bit fin;
    o = '{default: '0};
    req_n = 0;
    hs = -1;
    done_seen = 1'b0;
    fin = 1'b0;
    @(negedge clk);
    core_valid    = 1'b1;
    core_we       = s.we;
    core_funct3   = s.f3;
    core_addr     = s.addr;
    core_wdata    = s.wdata;
    bus_req_ready = 1'b0;
    bus_rsp_valid = 1'b0;
    @(negedge clk);
    c = 2;
    while (!fin && c < 40) begin
      if (done_seen) begin
        if (core_done) o.done_cnt++;
        o.busy_after  = busy;
        core_valid    = 1'b0;
        bus_req_ready = 1'b0;
        bus_rsp_valid = 1'b0;
        fin = 1'b1;
      end else begin
        if (!busy) o.busy_bad = 1'b1;
        if (core_done) begin
          done_seen  = 1'b1;
          o.done_cnt++;
          o.done_cyc = c;
          o.err      = core_err;
          o.rdata    = core_rdata;
        end
        if (bus_req_valid) begin
          req_n++;
          if (!o.req) begin
            o.req   = 1'b1;
            o.we    = bus_we;
            o.addr  = bus_addr;
            o.wdata = bus_wdata;
            o.wstrb = bus_wstrb;
          end else if ({bus_we, bus_addr, bus_wdata, bus_wstrb} !==
                       {o.we, o.addr, o.wdata, o.wstrb}) begin
            o.unstable = 1'b1;
          end
        end
        bus_req_ready = bus_req_valid && (req_n > s.rdly);
        if (bus_req_ready) hs = c;
        if (hs >= 0 && c > hs && !core_done) begin
          bus_rsp_valid = (c - hs == s.rsp_k);
          bus_rsp_err   = s.rsp_err;
          bus_rdata     = s.rdata;
        end else begin
          bus_rsp_valid = 1'($urandom_range(0, 1));
          bus_rsp_err   = 1'($urandom_range(0, 1));
          bus_rdata     = {$urandom, $urandom};
        end
        core_valid  = 1'($urandom_range(0, 1));
        core_we     = 1'($urandom_range(0, 1));
        core_funct3 = 3'($urandom_range(0, 7));
        core_addr   = {$urandom, $urandom};
        core_wdata  = {$urandom, $urandom};
        @(negedge clk);
        c++;
      end
    end
    if (!fin) begin
      // Budget expired: resynchronise the DUT so later transactions still run.
      core_valid    = 1'b0;
      bus_rsp_valid = 1'b0;
      bus_req_ready = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
    end
  endtask

  task automatic cmp_txn(input string tag, input obs_t o, input exp_t e);
    chk({tag, " done_cnt"}, 64'(o.done_cnt), 64'd1);
    chk({tag, " done_cyc"}, 64'(o.done_cyc), 64'(e.done_cyc));
    chk({tag, " err"}, 64'(o.err), 64'(e.err));
    chk({tag, " rdata"}, o.rdata, e.rdata);
    chk({tag, " busy"}, {62'd0, o.busy_bad, o.busy_after}, 64'd0);
    chk({tag, " req_seen"}, 64'(o.req), 64'(e.req));
    if (e.req) begin
      chk({tag, " bus_stable"}, 64'(o.unstable), 64'd0);
      chk({tag, " bus_we"}, 64'(o.we), 64'(e.we));
      chk({tag, " bus_addr"}, o.addr, e.addr);
      chk({tag, " bus_wstrb"}, 64'(o.wstrb), 64'(e.wstrb));
      if (e.we) chk({tag, " bus_wdata"}, o.wdata, e.wdata);
    end
  endtask

  vec_t  tbl[13];
  stim_t s;
  exp_t  e;
  obs_t  o;

  initial begin
    // {we, f3, addr, wdata, rdly, rsp_k, rsp_err, rdata} ,
    // {req, we, bus_addr, bus_wdata, wstrb, err, rdata, done_cyc}
    tbl[0]  = '{'{1'b0, 3'b000, 64'h80000003, 64'h0, 0, 1, 1'b0, 64'h00000000_80FF0000},
                '{1'b1, 1'b0, 64'h80000000, 64'h0, 8'hFF, 1'b0, 64'hFFFFFFFF_FFFFFF80, 4}};
    tbl[1]  = '{'{1'b0, 3'b110, 64'h80000004, 64'h0, 1, 2, 1'b0, 64'h89ABCDEF_01234567},
                '{1'b1, 1'b0, 64'h80000000, 64'h0, 8'hFF, 1'b0, 64'h00000000_89ABCDEF, 6}};
    tbl[2]  = '{'{1'b1, 3'b001, 64'h80000006, 64'h1234, 3, 1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF},
                '{1'b1, 1'b1, 64'h80000000, 64'h1234_0000_0000_0000, 8'hC0, 1'b0, 64'h0, 7}};
    tbl[3]  = '{'{1'b0, 3'b011, 64'h80000004, 64'h0, 0, 1, 1'b0, 64'h0},
                '{1'b0, 1'b0, 64'h0, 64'h0, 8'h00, 1'b1, 64'h0, 2}};
    tbl[4]  = '{'{1'b0, 3'b010, 64'h80000010, 64'h0, 0, 9, 1'b0, 64'h0},
                '{1'b1, 1'b0, 64'h80000010, 64'h0, 8'hFF, 1'b1, 64'h0, 7}};
    tbl[5]  = '{'{1'b0, 3'b011, 64'h80000008, 64'h0, 0, 1, 1'b1, 64'h1234},
                '{1'b1, 1'b0, 64'h80000008, 64'h0, 8'hFF, 1'b1, 64'h0, 4}};
    tbl[6]  = '{'{1'b0, 3'b001, 64'h80000002, 64'h0, 0, 4, 1'b0, 64'h00000000_80010000},
                '{1'b1, 1'b0, 64'h80000000, 64'h0, 8'hFF, 1'b0, 64'hFFFFFFFF_FFFF8001, 7}};
    tbl[7]  = '{'{1'b1, 3'b111, 64'h80000000, 64'h55, 0, 1, 1'b0, 64'h0},
                '{1'b0, 1'b0, 64'h0, 64'h0, 8'h00, 1'b1, 64'h0, 2}};
    tbl[8]  = '{'{1'b1, 3'b000, 64'h80000005, 64'hAB, 0, 1, 1'b0, 64'hFFFF_0000_FFFF_0000},
                '{1'b1, 1'b1, 64'h80000000, 64'h0000_AB00_0000_0000, 8'h20, 1'b0, 64'h0, 4}};
    tbl[9]  = '{'{1'b1, 3'b011, 64'h00000008, 64'hCAFEBABE_12345678, 2, 3, 1'b0, 64'h0},
                '{1'b1, 1'b1, 64'h00000008, 64'hCAFEBABE_12345678, 8'hFF, 1'b0, 64'h0, 8}};
    tbl[10] = '{'{1'b0, 3'b101, 64'h00000006, 64'h0, 0, 1, 1'b0, 64'hBEEF_0000_0000_0000},
                '{1'b1, 1'b0, 64'h00000000, 64'h0, 8'hFF, 1'b0, 64'h0000_0000_0000_BEEF, 4}};
    tbl[11] = '{'{1'b0, 3'b100, 64'h80000001, 64'h0, 0, 1, 1'b0, 64'h0000_0000_0000_F000},
                '{1'b1, 1'b0, 64'h80000000, 64'h0, 8'hFF, 1'b0, 64'h0000_0000_0000_00F0, 4}};
    tbl[12] = '{'{1'b1, 3'b010, 64'h00000002, 64'h1, 0, 1, 1'b0, 64'h0},
                '{1'b0, 1'b0, 64'h0, 64'h0, 8'h00, 1'b1, 64'h0, 2}};

    rst = 1'b0;
    core_valid = 1'b0; core_we = 1'b0; core_funct3 = 3'b000;
    core_addr = '0; core_wdata = '0;
    bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rdata = '0; bus_rsp_err = 1'b0;
    #12;
    chk("reset ctl", {59'd0, busy, core_done, core_err, bus_req_valid, bus_we}, 64'd0);
    chk("reset core_rdata", core_rdata, 64'd0);
    chk("reset bus_addr", bus_addr, 64'd0);
    chk("reset bus_wdata", bus_wdata, 64'd0);
    chk("reset bus_wstrb", 64'(bus_wstrb), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 13; i++) begin
      run_txn(tbl[i].s, o);
      cmp_txn($sformatf("vec%0d", i), o, tbl[i].e);
    end

    // Reset while waiting for a response abandons the transaction.
    @(negedge clk);
    core_valid = 1'b1; core_we = 1'b0; core_funct3 = 3'b011; core_addr = 64'h80000008;
    @(negedge clk);
    core_valid = 1'b0;
    bus_req_ready = 1'b1;
    @(negedge clk);
    bus_req_ready = 1'b0;
    chk("abort waiting", {62'd0, busy, bus_req_valid}, 64'd2);
    #2 rst = 1'b0;
    #1;
    chk("abort ctl", {59'd0, busy, core_done, core_err, bus_req_valid, bus_we}, 64'd0);
    chk("abort outputs", core_rdata | bus_addr | bus_wdata | 64'(bus_wstrb), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    bus_rsp_valid = 1'b1;
    bus_rdata = 64'h1111_2222_3333_4444;
    @(negedge clk);
    bus_rsp_valid = 1'b0;
    chk("abort no done", {62'd0, core_done, busy}, 64'd0);
    @(negedge clk);
    chk("abort still idle", {62'd0, core_done, busy}, 64'd0);
    s = '{1'b0, 3'b011, 64'h80000008, 64'h0, 0, 1, 1'b0, 64'h01234567_89ABCDEF};
    e = '{1'b1, 1'b0, 64'h80000008, 64'h0, 8'hFF, 1'b0, 64'h01234567_89ABCDEF, 4};
    run_txn(s, o);
    cmp_txn("after_abort", o, e);

    for (int i = 0; i < 200; i++) begin
      s.we      = 1'($urandom_range(0, 1));
      s.f3      = 3'($urandom_range(0, 7));
      s.addr    = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) begin
        case (s.f3[1:0])
          2'b01:   s.addr[0] = 1'b0;
          2'b10:   s.addr[1:0] = 2'b00;
          2'b11:   s.addr[2:0] = 3'b000;
          default: ;
        endcase
      end
      s.wdata   = {$urandom, $urandom};
      s.rdly    = $urandom_range(0, 3);
      s.rsp_k   = $urandom_range(1, 6);
      s.rsp_err = ($urandom_range(0, 7) == 0);
      s.rdata   = {$urandom, $urandom};
      run_txn(s, o);
      cmp_txn($sformatf("rnd%0d", i), o, model(s));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lsu_bus_bridge.md
Name: lsu_bus_bridge

Overview:
Load/store unit between the core's data-memory port and the shared data bus. It takes one load or store request at a time from the execute stage (address, funct3 size code, store data) and checks alignment. It drives a valid/ready request channel plus a response channel toward memory, and returns a sign- or zero-extended load result with a one-cycle done pulse. Sits directly downstream of the core top's mem_r/mem_w/mem_addr/mem_data interface; the core stalls while busy is high.

Parameters:
XLEN, 64, data/address width; bus data width equals XLEN
TIMEOUT, 255, max cycles in WAIT_RSP before aborting with error; 0 disables timeout

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
core_valid  in  1  request strobe from execute stage; sampled only in IDLE
core_we  in  1  1 = store, 0 = load
core_funct3  in  3  RV64 size code: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU, 111 illegal
core_addr  in  XLEN  byte address
core_wdata  in  XLEN  store data, right-aligned
core_rdata  out  XLEN  extended load result, valid with core_done
core_done  out  1  one-cycle completion pulse
core_err  out  1  valid with core_done: misaligned, illegal size, bus error or timeout
busy  out  1  high from accept through the core_done cycle
bus_req_valid  out  1  request valid
bus_req_ready  in  1  request accepted when valid&ready
bus_we  out  1  write enable
bus_addr  out  XLEN  core_addr with bits [2:0] cleared
bus_wdata  out  XLEN  store data shifted to byte lanes
bus_wstrb  out  8  byte-lane enables; all 1s on reads
bus_rsp_valid  in  1  response valid, single cycle
bus_rdata  in  XLEN  read data, full aligned doubleword
bus_rsp_err  in  1  response error flag

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0 (core_rdata, bus_addr, bus_wdata, bus_wstrb included); timeout counter 0. Reset mid-transaction abandons it; no done pulse follows.
- FSM states: IDLE, REQ, WAIT_RSP, DONE.
- IDLE, core_valid=1: latch we/funct3/addr/wdata; busy=1 next cycle.
  - Size 1/2/4/8 bytes (funct3[1:0]). Misaligned: addr[0]≠0 for H, addr[1:0]≠0 for W, addr[2:0]≠0 for D. Misaligned or funct3=111 (load or store) -> DONE with err=1. No bus activity.
  - Otherwise -> REQ.
- REQ: bus_req_valid=1; bus_we, bus_addr, bus_wdata, bus_wstrb stable until handshake. bus_wstrb = ((1<<size)-1) << addr[2:0]. bus_wdata = wdata << (8*addr[2:0]). On bus_req_ready -> WAIT_RSP, valid drops next cycle.
- WAIT_RSP: counter increments each cycle. On bus_rsp_valid -> DONE; capture err = bus_rsp_err. For loads, extract bus_rdata >> (8*addr[2:0]), truncate to size, then sign-extend (funct3[2]=0) or zero-extend (funct3[2]=1). If TIMEOUT≠0 and counter reaches TIMEOUT without a response -> DONE with err=1. A response arriving the same cycle as the timeout wins (no error unless bus_rsp_err).
- DONE: core_done=1 for exactly one cycle, plus core_rdata/core_err. Stores and errored transactions give core_rdata=0. -> IDLE. busy drops next cycle. core_valid in DONE is ignored.
- bus_rsp_valid outside WAIT_RSP is ignored.
- Minimum latency, accept to done, with ready and rsp each one cycle after they are first eligible: 4 cycles (accept, REQ, WAIT_RSP, DONE).
- Single outstanding transaction; no pipelining.

Test Plan:
1. Load byte with sign extension: LB addr=0x80000003, bus_rdata=0x00000000_80FF0000 -> wstrb=0xFF, bus_addr=0x80000000, core_rdata=0xFFFFFFFF_FFFFFF80, err=0, done one cycle.
2. Load word unsigned: LWU addr=0x80000004, bus_rdata=0x89ABCDEF_01234567 -> core_rdata=0x00000000_89ABCDEF.
3. Store halfword: SH addr=0x80000006, wdata=0x1234 -> bus_wstrb=0xC0, bus_wdata=0x1234_0000_0000_0000, bus_we=1. With ready held 0 for 3 cycles, bus outputs stay stable, then done with err=0.
4. Misaligned: LD addr=0x80000004 -> no bus_req_valid ever, core_done 2 cycles after accept with err=1, core_rdata=0.
5. Timeout/bus error: TIMEOUT=4, no rsp -> err=1 after 4 WAIT_RSP cycles. Separate run with rsp_valid and rsp_err=1 -> err=1.
6. Reset mid-WAIT_RSP: pull rst low -> all outputs 0 immediately. A later rsp_valid produces no done. A new LD addr=0x80000008 then completes normally.
